// File: rtl/mac_layer_if.sv
// Memory-side bus of the fully-connected layer engine.
// The engine uses the master modport. A memory model or wrapper uses the slave modport.
//   data_rd_en / data_rd_addr / data_rd_data : input-vector read port
//   wgt_rd_en  / wgt_rd_addr  / wgt_rd_data  : weight-row read port (LANES weights per row)
//   res_wr_en  / res_wr_addr  / res_wr_data  : result write port
// Read data returns MEM_LATENCY cycles after the strobe (latency is set on the engine).
interface mac_layer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int LANES        = 4,
  parameter int ADDR_WIDTH   = 32
);
  logic                            data_rd_en;
  logic [ADDR_WIDTH-1:0]           data_rd_addr;
  logic signed [DATA_WIDTH-1:0]    data_rd_data;
  logic                            wgt_rd_en;
  logic [ADDR_WIDTH-1:0]           wgt_rd_addr;
  logic [LANES*WEIGHT_WIDTH-1:0]   wgt_rd_data;
  logic                            res_wr_en;
  logic [ADDR_WIDTH-1:0]           res_wr_addr;
  logic signed [DATA_WIDTH-1:0]    res_wr_data;

  modport master (
    output data_rd_en, data_rd_addr,
    input  data_rd_data,
    output wgt_rd_en, wgt_rd_addr,
    input  wgt_rd_data,
    output res_wr_en, res_wr_addr, res_wr_data
  );

  modport slave (
    input  data_rd_en, data_rd_addr,
    output data_rd_data,
    input  wgt_rd_en, wgt_rd_addr,
    output wgt_rd_data,
    input  res_wr_en, res_wr_addr, res_wr_data
  );
endinterface

// File: rtl/mac_layer_engine.sv
// Fully-connected layer engine. It computes LANES output neurons in parallel per group.
// Each neuron is a dot product plus a bias, followed by an optional ReLU, an arithmetic
// right shift, and saturation to DATA_WIDTH.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   go              : start pulse. It latches every config input and is ignored while busy.
//   layer_index     : tag echoed on cur_layer
//   data_address, data_size (N), weight_address, out_count (M), result_address,
//   relu_en, shift  : layer configuration
//   cur_layer, busy, done : status (done is a one-cycle pulse with busy low)
//   mem             : memory bus (mac_layer_if.master)
// Weight layout: group g, row r (0..N) is at weight_address + g*(N+1) + r.
// Row N holds the per-lane biases.
module mac_layer_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int LANES        = 4,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEM_LATENCY  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [2:0]            layer_index,
  input  logic [ADDR_WIDTH-1:0] data_address,
  input  logic [ADDR_WIDTH-1:0] data_size,
  input  logic [ADDR_WIDTH-1:0] weight_address,
  input  logic [ADDR_WIDTH-1:0] out_count,
  input  logic [ADDR_WIDTH-1:0] result_address,
  input  logic                  relu_en,
  input  logic [4:0]            shift,
  output logic [2:0]            cur_layer,
  output logic                  busy,
  output logic                  done,
  mac_layer_if.master           mem
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  function automatic logic signed [WEIGHT_WIDTH-1:0] lane_weight(
    input logic [LANES*WEIGHT_WIDTH-1:0] row, input int i);
    return row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] mul_ext(
    input logic signed [DATA_WIDTH-1:0] a, input logic signed [WEIGHT_WIDTH-1:0] b);
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return ACC_WIDTH'(p);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] requant(
    input logic signed [ACC_WIDTH-1:0] a, input logic relu, input logic [4:0] sh);
    logic signed [ACC_WIDTH-1:0] v;
    v = (relu && a[ACC_WIDTH-1]) ? '0 : a;
    v = v >>> sh;
    if (v > SAT_MAX)      return SAT_MAX[DATA_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    else                  return v[DATA_WIDTH-1:0];
  endfunction

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       row_q, row_d;
  logic [ADDR_WIDTH-1:0]       wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]       group_q, group_d;
  logic [LW-1:0]               lane_q, lane_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]       data_addr_q, data_addr_d;
  logic [ADDR_WIDTH-1:0]       n_q, n_d;
  logic [ADDR_WIDTH-1:0]       m_q, m_d;
  logic [ADDR_WIDTH-1:0]       res_addr_q, res_addr_d;
  logic                        relu_q, relu_d;
  logic [4:0]                  shift_q, shift_d;
  logic [2:0]                  layer_q, layer_d;
  logic                        done_q, done_d;
  logic [MEM_LATENCY-1:0]      vld_pipe_q, vld_pipe_d;
  logic [MEM_LATENCY-1:0]      bias_pipe_q, bias_pipe_d;
  logic signed [ACC_WIDTH-1:0] acc_q [LANES];
  logic signed [ACC_WIDTH-1:0] acc_d [LANES];
  logic signed [ACC_WIDTH-1:0] term [LANES];
  logic                        issue, issue_bias, clear_acc;
  logic [ADDR_WIDTH-1:0]       out_idx;

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cur_layer = layer_q;

  // Beat returning from memory: a product for data rows, the raw bias for the last row.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      if (bias_pipe_q[MEM_LATENCY-1])
        term[i] = ACC_WIDTH'(lane_weight(mem.wgt_rd_data, i));
      else
        term[i] = mul_ext(mem.data_rd_data, lane_weight(mem.wgt_rd_data, i));
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    wptr_d       = wptr_q;
    group_d      = group_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    data_addr_d  = data_addr_q;
    n_d          = n_q;
    m_d          = m_q;
    res_addr_d   = res_addr_q;
    relu_d       = relu_q;
    shift_d      = shift_q;
    layer_d      = layer_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    issue_bias   = 1'b0;
    clear_acc    = 1'b0;
    out_idx      = group_q + ADDR_WIDTH'(lane_q);
    mem.data_rd_en   = 1'b0;
    mem.data_rd_addr = '0;
    mem.wgt_rd_en    = 1'b0;
    mem.wgt_rd_addr  = '0;
    mem.res_wr_en    = 1'b0;
    mem.res_wr_addr  = '0;
    mem.res_wr_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (go) begin
          data_addr_d = data_address;
          n_d         = data_size;
          m_d         = out_count;
          res_addr_d  = result_address;
          relu_d      = relu_en;
          shift_d     = shift;
          layer_d     = layer_index;
          wptr_d      = weight_address;
          group_d     = '0;
          row_d       = '0;
          if (out_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_FETCH;
            clear_acc = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // Weight rows of consecutive groups are contiguous, so one running pointer suffices.
        issue            = 1'b1;
        issue_bias       = (row_q == n_q);
        mem.wgt_rd_en    = 1'b1;
        mem.wgt_rd_addr  = wptr_q;
        mem.data_rd_en   = (row_q != n_q);
        mem.data_rd_addr = (row_q != n_q) ? data_addr_q + row_q : '0;
        wptr_d           = wptr_q + 1'b1;
        if (row_q == n_q) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == CW'(MEM_LATENCY - 1)) begin
          state_d = S_WRITE;
          lane_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        // Lanes past the last output of a partial group are stepped through silently.
        mem.res_wr_en   = (out_idx < m_q);
        mem.res_wr_addr = res_addr_q + out_idx;
        mem.res_wr_data = requant(acc_q[lane_q], relu_q, shift_q);
        if (lane_q == LW'(LANES - 1)) begin
          if (group_q + ADDR_WIDTH'(LANES) < m_q) begin
            state_d   = S_FETCH;
            group_d   = group_q + ADDR_WIDTH'(LANES);
            row_d     = '0;
            clear_acc = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          lane_d = lane_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    vld_pipe_d[0]  = issue;
    bias_pipe_d[0] = issue_bias;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      bias_pipe_d[i] = bias_pipe_q[i-1];
    end

    for (int i = 0; i < LANES; i++) begin
      if (clear_acc)
        acc_d[i] = '0;
      else if (vld_pipe_q[MEM_LATENCY-1])
        acc_d[i] = acc_q[i] + term[i];
      else
        acc_d[i] = acc_q[i];
    end
  end

  // Stage boundary: control, config latches, valid pipeline and accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      wptr_q      <= '0;
      group_q     <= '0;
      lane_q      <= '0;
      cnt_q       <= '0;
      data_addr_q <= '0;
      n_q         <= '0;
      m_q         <= '0;
      res_addr_q  <= '0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      layer_q     <= '0;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      bias_pipe_q <= '0;
      acc_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      wptr_q      <= wptr_d;
      group_q     <= group_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      data_addr_q <= data_addr_d;
      n_q         <= n_d;
      m_q         <= m_d;
      res_addr_q  <= res_addr_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      layer_q     <= layer_d;
      done_q      <= done_d;
      vld_pipe_q  <= vld_pipe_d;
      bias_pipe_q <= bias_pipe_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_mac_layer_engine.sv
// Bench for mac_layer_engine. It uses a synchronous memory model and compares the written
// results against a reference dot-product model computed from the memory contents.
module tb_mac_layer_engine;
  localparam int DW = 8, WW = 8, AW = 32, LN = 4, ML = 1;
  localparam int DBASE = 16, WBASE = 64, RBASE = 200, LIMIT = 3000;

  logic          clk = 1'b0;
  logic          rst, go, relu_en;
  logic [2:0]    layer_index, cur_layer;
  logic [AW-1:0] data_address, data_size, weight_address, out_count, result_address;
  logic [4:0]    shift;
  logic          busy, done;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  logic signed [7:0] dmem [256];
  logic [31:0]       wmem [256];
  logic [AW-1:0]     wr_addr_q [$];
  logic signed [7:0] wr_data_q [$];
  logic [AW-1:0]     drd_q [$];
  logic [AW-1:0]     wrd_q [$];

  always #5 clk = ~clk;

  mac_layer_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .LANES(LN), .ADDR_WIDTH(AW)) mif ();

  mac_layer_engine #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACC_WIDTH(32), .LANES(LN),
                     .ADDR_WIDTH(AW), .MEM_LATENCY(ML)) dut (
    .clk(clk), .rst(rst), .go(go), .layer_index(layer_index),
    .data_address(data_address), .data_size(data_size), .weight_address(weight_address),
    .out_count(out_count), .result_address(result_address), .relu_en(relu_en),
    .shift(shift), .cur_layer(cur_layer), .busy(busy), .done(done), .mem(mif)
  );

  // One-cycle-latency synchronous memories.
  always @(posedge clk) begin
    if (mif.data_rd_en) mif.data_rd_data <= dmem[mif.data_rd_addr[7:0]];
    if (mif.wgt_rd_en)  mif.wgt_rd_data  <= wmem[mif.wgt_rd_addr[7:0]];
  end

  always @(negedge clk) begin
    if (mif.res_wr_en) begin
      wr_addr_q.push_back(mif.res_wr_addr);
      wr_data_q.push_back(mif.res_wr_data);
    end
    if (mif.data_rd_en) drd_q.push_back(mif.data_rd_addr);
    if (mif.wgt_rd_en)  wrd_q.push_back(mif.wgt_rd_addr);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] wdat(input int i);
    if (i < wr_data_q.size()) return 64'(wr_data_q[i]);
    return 'x;
  endfunction

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  // Reference: output k = requant(sum_r x[r]*W[g][r][lane] + bias[g][lane]).
  function automatic int exp_out(input int k, input int n, input bit relu, input int sh);
    int g, ln, acc;
    logic [31:0] row;
    logic signed [7:0] w;
    g = k / LN; ln = k % LN; acc = 0;
    for (int r = 0; r < n; r++) begin
      row = wmem[WBASE + g*(n+1) + r];
      w = row[ln*8 +: 8];
      acc += int'(dmem[DBASE + r]) * int'(w);
    end
    row = wmem[WBASE + g*(n+1) + n];
    w = row[ln*8 +: 8];
    acc += int'(w);
    if (relu && acc < 0) acc = 0;
    acc = acc >>> sh;
    if (acc > 127) acc = 127;
    else if (acc < -128) acc = -128;
    return acc;
  endfunction

  task automatic load_test1();
    dmem[DBASE] = 8'sd1; dmem[DBASE+1] = 8'sd2; dmem[DBASE+2] = 8'sd3;
    wmem[WBASE]   = pack4(1, 2, -1, 0);
    wmem[WBASE+1] = pack4(1, 0, -1, 0);
    wmem[WBASE+2] = pack4(1, 0, -1, 5);
    wmem[WBASE+3] = pack4(0, 3, 0, 1);
  endtask

  task automatic fill_random(input int n, input int rows);
    for (int r = 0; r < n; r++) dmem[DBASE + r] = 8'($urandom);
    for (int j = 0; j < rows; j++) wmem[WBASE + j] = $urandom;
  endtask

  task automatic set_cfg(input logic [2:0] tagv, input int n, input int m, input bit relu, input int sh);
    layer_index = tagv; data_address = DBASE; data_size = AW'(n); weight_address = WBASE;
    out_count = AW'(m); result_address = RBASE; relu_en = relu; shift = 5'(sh);
  endtask

  task automatic run_layer(input string tag, input int n, input int m, input bit relu,
                           input int sh, input int extra_go);
    int cyc, grp, exp_cyc, base_done;
    logic [2:0] tagv;
    tagv = 3'($urandom);
    wr_addr_q.delete(); wr_data_q.delete(); drd_q.delete(); wrd_q.delete();
    base_done = done_cnt;
    set_cfg(tagv, n, m, relu, sh);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 1;
    chk($sformatf("%s/busy_start", tag), busy, 1);
    while (!done && cyc < LIMIT) begin
      if (cyc == extra_go) begin
        go = 1'b1; data_size = AW'(n + 2); out_count = AW'(1); relu_en = !relu;
        shift = 5'(sh + 1); weight_address = WBASE + 1;
      end else begin
        go = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    go = 1'b0;
    grp = (m + LN - 1) / LN;
    exp_cyc = grp * (n + 1 + ML + LN) + 2;
    chk($sformatf("%s/done_seen", tag), done, 1);
    chk($sformatf("%s/latency", tag), cyc, exp_cyc);
    chk($sformatf("%s/busy_at_done", tag), busy, 0);
    chk($sformatf("%s/cur_layer", tag), cur_layer, tagv);
    chk($sformatf("%s/n_writes", tag), wr_data_q.size(), m);
    for (int k = 0; k < m && k < wr_data_q.size(); k++) begin
      chk($sformatf("%s/waddr%0d", tag, k), wr_addr_q[k], RBASE + k);
      chk($sformatf("%s/wdata%0d", tag, k), wdat(k), exp_out(k, n, relu, sh));
    end
    chk($sformatf("%s/n_data_reads", tag), drd_q.size(), grp * n);
    for (int j = 0; j < drd_q.size() && j < grp * n; j++)
      chk($sformatf("%s/daddr%0d", tag, j), drd_q[j], DBASE + (j % n));
    chk($sformatf("%s/n_wgt_reads", tag), wrd_q.size(), grp * (n + 1));
    for (int j = 0; j < wrd_q.size() && j < grp * (n + 1); j++)
      chk($sformatf("%s/wgtaddr%0d", tag, j), wrd_q[j], WBASE + j);
    @(negedge clk);
    chk($sformatf("%s/done_pulse", tag), done, 0);
    repeat (6) @(negedge clk);
    chk($sformatf("%s/done_count", tag), done_cnt - base_done, 1);
    chk($sformatf("%s/writes_after", tag), wr_data_q.size(), m);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin dmem[i] = '0; wmem[i] = '0; end
    rst = 1'b1; go = 1'b0;
    set_cfg(3'd0, 0, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    chk("rst/busy", busy, 0);
    chk("rst/done", done, 0);
    chk("rst/data_rd_en", mif.data_rd_en, 0);
    chk("rst/wgt_rd_en", mif.wgt_rd_en, 0);
    chk("rst/res_wr_en", mif.res_wr_en, 0);
    chk("rst/cur_layer", cur_layer, 0);
    rst = 1'b0;
    @(negedge clk);

    load_test1();
    run_layer("t1", 3, 4, 1'b0, 0, 0);
    chk("t1/c0", wdat(0), 6);  chk("t1/c1", wdat(1), 5);
    chk("t1/c2", wdat(2), -6); chk("t1/c3", wdat(3), 16);

    run_layer("t1relu", 3, 4, 1'b1, 0, 0);
    chk("relu/c2", wdat(2), 0); chk("relu/c3", wdat(3), 16);

    dmem[DBASE] = 8'sd100;
    wmem[WBASE] = pack4(10, -10, 4, -3);
    wmem[WBASE+1] = pack4(0, 0, 0, 0);
    run_layer("sat", 1, 4, 1'b0, 2, 0);
    chk("sat/pos", wdat(0), 127); chk("sat/neg", wdat(1), -128);
    chk("sat/mid", wdat(2), 100); chk("sat/nmid", wdat(3), -75);

    wmem[WBASE] = pack4(7, -7, 0, 200);
    run_layer("n0", 0, 4, 1'b0, 0, 0);
    chk("n0/c0", wdat(0), 7);  chk("n0/c1", wdat(1), -7);
    chk("n0/c2", wdat(2), 0);  chk("n0/c3", wdat(3), -56);

    run_layer("m0", 3, 0, 1'b0, 0, 0);

    fill_random(3, 8);
    run_layer("m6", 3, 6, 1'b0, 3, 0);

    // Abort in the middle of FETCH.
    load_test1();
    set_cfg(3'd5, 3, 4, 1'b0, 0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("abort/fetching", mif.wgt_rd_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort/data_rd_en", mif.data_rd_en, 0);
    chk("abort/wgt_rd_en", mif.wgt_rd_en, 0);
    chk("abort/res_wr_en", mif.res_wr_en, 0);
    chk("abort/busy", busy, 0);
    chk("abort/done", done, 0);
    begin
      int base;
      base = done_cnt;
      wr_data_q.delete(); wrd_q.delete();
      repeat (12) @(negedge clk);
      chk("abort/no_writes", wr_data_q.size(), 0);
      chk("abort/no_reads", wrd_q.size(), 0);
      chk("abort/no_done", done_cnt - base, 0);
    end
    run_layer("rerun", 3, 4, 1'b0, 0, 0);
    chk("rerun/c0", wdat(0), 6);  chk("rerun/c2", wdat(2), -6);
    chk("rerun/c3", wdat(3), 16);

    fill_random(2, 6);
    run_layer("gobusy", 2, 6, 1'b1, 1, 3);

    for (int it = 0; it < 6; it++) begin
      int n, m;
      n = $urandom_range(0, 5);
      m = $urandom_range(1, 10);
      fill_random(n, 3 * (n + 1));
      run_layer($sformatf("rnd%0d", it), n, m, 1'($urandom), $urandom_range(0, 12), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
